// File: rtl/seq_divider_pkg.sv
// Shared state encoding and width-generic sign helpers for the iterative divider.
// Helpers work on MAX_W-bit containers; callers pass their true width.
package divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  // Two's-complement negation confined to the low w bits.
  function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] x, input int w);
    return (~x + MAX_W'(1)) & width_mask(w);
  endfunction

  // Magnitude of a w-bit value; the most negative value maps to itself,
  // which is exactly the unsigned magnitude the datapath needs.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x,
                                             input logic signed_en,
                                             input int w);
    if (signed_en && x[w-1]) begin
      return neg_w(x, w);
    end
    return x & width_mask(w);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift the partial remainder
// left by one pulling in the next dividend bit, subtract the divisor if it fits.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_n,
  output logic [WIDTH-1:0] acc_n
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;
  logic           unused_top;

  // The partial remainder is always below the divisor, so its top bit is
  // zero here and dropping it during the shift loses nothing.
  assign shifted    = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign diff       = shifted - {1'b0, dvs};
  assign fits       = (shifted >= {1'b0, dvs});
  assign rem_n      = fits ? diff : shifted;
  assign acc_n      = {acc[WIDTH-2:0], fits};
  assign unused_top = rem[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional build macro: DIV_EARLY_OUT_EN (finish in one cycle when |dividend| < |divisor|).
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);
  import divider_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic             div_zero;
  logic             early_out;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign abs_dvd  = WIDTH'(abs_w(MAX_W'(dividend), is_signed, WIDTH));
  assign abs_dvs  = WIDTH'(abs_w(MAX_W'(divisor), is_signed, WIDTH));
  assign div_zero = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_zero && (abs_dvd < abs_dvs);
`else
  assign early_out = 1'b0;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem   (rem),
    .acc   (acc),
    .dvs   (dvs),
    .rem_n (step_rem),
    .acc_n (step_acc)
  );

  // Sign fix-up is applied to the final step's output so the result lands
  // in the same edge that enters DONE.
  assign q_fix = q_neg ? WIDTH'(neg_w(MAX_W'(step_acc), WIDTH)) : step_acc;
  assign r_fix = r_neg ? WIDTH'(neg_w(MAX_W'(step_rem[WIDTH-1:0]), WIDTH))
                       : step_rem[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      rem       <= '0;
      acc       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            rem   <= '0;
            acc   <= abs_dvd;
            dvs   <= abs_dvs;
            q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed && dividend[WIDTH-1];
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dividend;
              state     <= S_DONE;
            end else if (early_out) begin
              quotient  <= '0;
              remainder <= dividend;
              state     <= S_DONE;
            end else begin
              count <= CNT_W'(WIDTH);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem   <= step_rem;
          acc   <= step_acc;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, remainders and latencies.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands, measure edges from accept (inclusive) to out_valid,
  // check the result, optionally hold backpressure, then hand off.
  task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_q,
                       input logic [31:0] exp_r, input int exp_lat, input int hold);
    int lat;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    if (!out_valid) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".in_ready_calc"}, 32'(in_ready), 32'd0);
    end
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".q"}, quotient, exp_q);
    check({tag, ".r"}, remainder, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_q"}, quotient, exp_q);
      check({tag, ".hold_r"}, remainder, exp_r);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".handoff_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".handoff_busy"}, 32'(busy), 32'd0);
    $display("op %s: a=%h b=%h signed=%0d q=%h r=%h latency=%0d", tag, a, b, sgn,
             quotient, remainder, lat);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.q", quotient, 32'd0);
    check("reset.r", remainder, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
    do_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    do_op("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0);
    do_op("udiv_by0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1, 0);
    do_op("sdiv_m5_by0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0);
    do_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);
    do_op("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 0);
    do_op("udiv_max_2s", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 33, 0);
    do_op("bp_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 10);
    do_op("sdiv_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 0);

    // Abort mid-calculation with reset at the 15th CALC cycle.
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    check("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.q", quotient, 32'd0);
    check("abort.r", remainder, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort.no_result", 32'(seen), 32'd0);
    $display("op abort: reset applied mid-calculation, out_valid cycles seen=%0d", seen);

    do_op("udiv_3_5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd3, SMALL_LAT, 0);
    do_op("sdiv_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'hFFFF_FFFD, SMALL_LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
